// File: rtl/bcd_updown_chain_if.sv
// Control/status bundle between the tick prescaler, the BCD counter chain and the display mux.
// The master drives the step/load controls; the slave (the counter) returns count and flags.
interface bcd_updown_chain_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      en;
    logic                      up_dn;
    logic                      clear;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   load_val;
    logic [4*NUM_DIGITS-1:0]   count;
    logic                      tc;
    logic                      at_zero;
    logic                      at_max;

    modport master (
        output en, up_dn, clear, load, load_val,
        input  count, tc, at_zero, at_max
    );

    modport slave (
        input  en, up_dn, clear, load, load_val,
        output count, tc, at_zero, at_max
    );
endinterface

// File: rtl/bcd_updown_chain.sv
// Registered N-digit BCD up/down counter with per-digit modulus, sync clear/load with clamping,
// single-cycle carry/borrow lookahead and an optional hold-at-zero countdown mode.
module bcd_updown_chain #(
    parameter int          NUM_DIGITS    = 4,
    parameter logic [31:0] DIGIT_MAX_VEC = 32'h0000_5959,
    parameter int          STOP_AT_ZERO  = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    bcd_updown_chain_if.slave        bus
);
    localparam int W         = 4 * NUM_DIGITS;
    localparam bit STOP_MODE = (STOP_AT_ZERO != 0);

    logic [W-1:0]          count_q;
    logic                  tc_q;
    logic [W-1:0]          count_step;
    logic [W-1:0]          load_clamped;
    logic [NUM_DIGITS-1:0] dig_zero;
    logic [NUM_DIGITS-1:0] dig_max;
    logic [NUM_DIGITS-1:0] step;
    logic                  at_zero;
    logic                  at_max;
    logic                  hold_zero;
    logic                  tc_d;

    // NOTE: every variable written in an always_comb gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        logic [3:0] digit;
        logic [3:0] mx;
        logic [3:0] ld;
        count_step   = '0;
        load_clamped = '0;
        dig_zero     = '0;
        dig_max      = '0;
        step         = '0;
        digit        = '0;
        mx           = '0;
        ld           = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit = count_q[4*i +: 4];
            mx    = DIGIT_MAX_VEC[4*i +: 4];
            ld    = bus.load_val[4*i +: 4];
            dig_zero[i] = (digit == 4'd0);
            dig_max[i]  = (digit == mx);
            load_clamped[4*i +: 4] = (ld > mx) ? mx : ld;

            // Lookahead: a digit steps when every lower digit sits at its terminal value.
            if (i == 0)
                step[i] = 1'b1;
            else
                step[i] = step[i-1] & (bus.up_dn ? dig_max[i-1] : dig_zero[i-1]);

            if (!step[i])
                count_step[4*i +: 4] = digit;
            else if (bus.up_dn)
                count_step[4*i +: 4] = (digit >= mx) ? 4'd0 : digit + 4'd1;
            else if (digit == 4'd0)
                count_step[4*i +: 4] = mx;
            else
                count_step[4*i +: 4] = (digit > mx) ? 4'd0 : digit - 4'd1;
        end
    end

    assign at_zero   = &dig_zero;
    assign at_max    = &dig_max;
    assign hold_zero = STOP_MODE && !bus.up_dn && at_zero;

    // Stop mode reports "countdown done" on the step that lands on zero, not while parked there.
    always_comb begin
        tc_d = 1'b0;
        if (bus.up_dn)
            tc_d = at_max;
        else if (STOP_MODE)
            tc_d = !at_zero && (count_step == '0);
        else
            tc_d = at_zero;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from
    // the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else if (bus.clear) begin
            count_q <= '0;
            tc_q    <= 1'b0;
        end else if (bus.load) begin
            count_q <= load_clamped;
            tc_q    <= 1'b0;
        end else if (bus.en) begin
            tc_q <= tc_d;
            if (!hold_zero)
                count_q <= count_step;
        end else begin
            tc_q <= 1'b0;
        end
    end

    assign bus.count   = count_q;
    assign bus.tc      = tc_q;
    assign bus.at_zero = at_zero;
    assign bus.at_max  = at_max;
endmodule
